// File: rtl/multiport_register_file.sv
// Multi-ported register file with per-register busy scoreboard, optional
// write-to-read bypass, hard-wired zero register and a sequential clear sweep.
module multiport_register_file #(
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     clear_req,
  output logic                     ready
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]    busy_q, busy_d;

  logic [ADDR_W-1:0]   wr_addr_a [NUM_WR];
  logic [DATA_W-1:0]   wr_data_a [NUM_WR];
  logic [ADDR_W-1:0]   rd_addr_a [NUM_RD];

  // Addresses past DEPTH and the hard-wired zero register are never stored,
  // forwarded or marked busy.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_addr_a[j] = wr_addr[j*ADDR_W +: ADDR_W];
      wr_data_a[j] = wr_data[j*DATA_W +: DATA_W];
    end
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // NOTE: the array is built from flops, not a RAM macro, so it can take the
  // asynchronous reset; all state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      regs_q  <= '{default: '0};
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);

  // Loop order gives the highest write port priority; the issue comes last so
  // it beats a same-cycle write on the busy bit.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (ready) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && addr_ok(wr_addr_a[j])) begin
          regs_d[wr_addr_a[j]] = wr_data_a[j];
          busy_d[wr_addr_a[j]] = 1'b0;
        end
      end
      if (issue_en && addr_ok(issue_addr)) begin
        busy_d[issue_addr] = 1'b1;
      end
    end else begin
      regs_d[cnt_q] = '0;
      busy_d[cnt_q] = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (addr_ok(rd_addr_a[i])) begin
        rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr_a[i]];
        rd_busy[i]                  = busy_q[rd_addr_a[i]];
        // Forwarding is gated by reset so outputs read zero while it is held.
        if ((BYPASS != 0) && ready && reset_n) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr_a[j] == rd_addr_a[i])) begin
              rd_data[i*DATA_W +: DATA_W] = wr_data_a[j];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: default, no-bypass and
// DEPTH=24 / 3-read / 1-write instances.
module tb_multiport_register_file;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        clear_req = 1'b0;

  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;
  logic        ready0, ready1;

  logic [0:0]  wr_en2 = '0;
  logic [4:0]  wr_addr2 = '0;
  logic [31:0] wr_data2 = '0;
  logic [14:0] rd_addr2 = '0;
  logic [95:0] rd_data2;
  logic [2:0]  rd_busy2;
  logic        ready2;
  logic        issue_en2 = 1'b0;
  logic [4:0]  issue_addr2 = '0;
  logic        clear_req2 = 1'b0;

  always #5 clk = ~clk;

  multiport_register_file dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .issue_en(issue_en), .issue_addr(issue_addr),
    .clear_req(clear_req), .ready(ready0)
  );

  multiport_register_file #(.BYPASS(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .issue_en(issue_en), .issue_addr(issue_addr),
    .clear_req(clear_req), .ready(ready1)
  );

  multiport_register_file #(.DEPTH(24), .NUM_RD(3), .NUM_WR(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rd_busy(rd_busy2), .issue_en(issue_en2), .issue_addr(issue_addr2),
    .clear_req(clear_req2), .ready(ready2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [31:0] v);
    exp_t x;
    x.name  = n;
    x.value = v;
    sb.push_back(x);
  endtask

  task automatic set_wr(input int j, input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en[j]            = en;
    wr_addr[j*5 +: 5]   = a;
    wr_data[j*32 +: 32] = d;
  endtask

  task automatic set_rd(input int i, input logic [4:0] a);
    rd_addr[i*5 +: 5] = a;
  endtask

  task automatic test_reset();
    set_wr(0, 1'b1, 5'd5, 32'h5555_AAAA);
    set_rd(0, 5'd5);
    #3;
    push("reset_rd_data", 32'h0);
    push("reset_rd_busy", 32'h0);
    push("reset_ready",   32'h1);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if ({30'b0, rd_busy0} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0, e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, ready0} !== e.value) $display("FAIL %s: got %h want %h", e.name, ready0, e.value);
    else pass_cnt++;
    wr_en = '0;
    #3 reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    tick();
    set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    wr_en = '0;
    set_rd(0, 5'd5);
    #1;
    push("read_back_5", 32'hDEAD_BEEF);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    set_wr(0, 1'b1, 5'd0, 32'h0000_1234);
    set_rd(1, 5'd0);
    #1;
    push("zero_reg_no_bypass", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[63:32] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[63:32], e.value);
    else pass_cnt++;
    tick();
    wr_en = '0;
    #1;
    push("zero_reg_stored", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[63:32] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[63:32], e.value);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    set_wr(0, 1'b1, 5'd7, 32'h11);
    set_wr(1, 1'b1, 5'd7, 32'h22);
    set_rd(0, 5'd7);
    #1;
    push("bypass_high_port", 32'h22);
    push("no_bypass_old",    32'h0);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if (rd_data1[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data1[31:0], e.value);
    else pass_cnt++;
    tick();
    wr_en = '0;
    #1;
    push("collision_stored",    32'h22);
    push("collision_stored_nb", 32'h22);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if (rd_data1[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data1[31:0], e.value);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    set_rd(1, 5'd9);
    issue_en = 1'b1;
    issue_addr = 5'd9;
    #1;
    push("busy_not_forwarded", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[1]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[1], e.value);
    else pass_cnt++;
    tick();
    issue_en = 1'b0;
    #1;
    push("busy_after_issue", 32'h1);
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[1]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[1], e.value);
    else pass_cnt++;
    set_wr(0, 1'b1, 5'd9, 32'h5);
    tick();
    wr_en = '0;
    #1;
    push("busy_cleared_by_write", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[1]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[1], e.value);
    else pass_cnt++;
    issue_en = 1'b1;
    set_wr(1, 1'b1, 5'd9, 32'h6);
    tick();
    issue_en = 1'b0;
    wr_en = '0;
    #1;
    push("issue_beats_write", 32'h1);
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[1]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[1], e.value);
    else pass_cnt++;
    set_rd(0, 5'd0);
    issue_en = 1'b1;
    issue_addr = 5'd0;
    tick();
    issue_en = 1'b0;
    #1;
    push("zero_reg_never_busy", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[0]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[0], e.value);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int cycles;
    for (int a = 1; a < 31; a++) begin
      set_wr(0, 1'b1, 5'(a), 32'hA500_0000 | 32'(a));
      tick();
    end
    // Write to 31 alongside the clear request: it lands, then gets swept.
    set_wr(0, 1'b1, 5'd31, 32'hA500_001F);
    clear_req = 1'b1;
    set_rd(0, 5'd17);
    #1;
    push("fill_value_17", 32'hA500_0011);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    tick();
    set_wr(0, 1'b1, 5'd3, 32'hFFFF_FFFF);
    issue_en = 1'b1;
    issue_addr = 5'd2;
    set_rd(0, 5'd3);
    set_rd(1, 5'd31);
    #1;
    push("clear_no_bypass_3", 32'hA500_0003);
    push("clear_stored_31",   32'hA500_001F);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[63:32] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[63:32], e.value);
    else pass_cnt++;
    cycles = 0;
    while (ready0 === 1'b0 && cycles < 100) begin
      cycles++;
      clear_req = (cycles < 20);
      tick();
    end
    wr_en = '0;
    issue_en = 1'b0;
    clear_req = 1'b0;
    push("ready_low_cycles", 32'd32);
    e = sb.pop_front(); total_cnt++;
    if (32'(cycles) !== e.value) $display("FAIL %s: got %0d want %0d", e.name, cycles, e.value);
    else pass_cnt++;
    for (int a = 0; a < 32; a += 2) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(a + 1));
      #1;
      push($sformatf("swept_data_%0d", a),     32'h0);
      push($sformatf("swept_data_%0d", a + 1), 32'h0);
      push($sformatf("swept_busy_%0d", a),     32'h0);
      e = sb.pop_front(); total_cnt++;
      if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
      else pass_cnt++;
      e = sb.pop_front(); total_cnt++;
      if (rd_data0[63:32] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[63:32], e.value);
      else pass_cnt++;
      e = sb.pop_front(); total_cnt++;
      if ({30'b0, rd_busy0} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0, e.value);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_clear();
    tick();
    set_wr(0, 1'b1, 5'd20, 32'h2020_2020);
    tick();
    wr_en = '0;
    issue_en = 1'b1;
    issue_addr = 5'd25;
    tick();
    issue_en = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    set_rd(0, 5'd20);
    set_rd(1, 5'd25);
    #1;
    push("mid_clear_unswept_20", 32'h2020_2020);
    push("mid_clear_busy_25",    32'h1);
    push("mid_clear_ready",      32'h0);
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[1]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[1], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, ready0} !== e.value) $display("FAIL %s: got %h want %h", e.name, ready0, e.value);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    push("async_ready",   32'h1);
    push("async_data_20", 32'h0);
    push("async_busy_25", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, ready0} !== e.value) $display("FAIL %s: got %h want %h", e.name, ready0, e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[1]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[1], e.value);
    else pass_cnt++;
    #4 reset_n = 1'b1;
    tick();
    #1;
    push("post_reset_ready",   32'h1);
    push("post_reset_data_20", 32'h0);
    push("post_reset_busy_25", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, ready0} !== e.value) $display("FAIL %s: got %h want %h", e.name, ready0, e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if (rd_data0[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data0[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy0[1]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy0[1], e.value);
    else pass_cnt++;
  endtask

  task automatic test_depth24();
    wr_en2 = 1'b1;
    wr_addr2 = 5'd30;
    wr_data2 = 32'hCAFE_F00D;
    issue_en2 = 1'b1;
    issue_addr2 = 5'd30;
    rd_addr2 = {5'd0, 5'd0, 5'd30};
    #1;
    push("oor_no_bypass", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if (rd_data2[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data2[31:0], e.value);
    else pass_cnt++;
    tick();
    wr_en2 = 1'b0;
    issue_en2 = 1'b0;
    #1;
    push("oor_read_zero", 32'h0);
    push("oor_busy_zero", 32'h0);
    e = sb.pop_front(); total_cnt++;
    if (rd_data2[31:0] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data2[31:0], e.value);
    else pass_cnt++;
    e = sb.pop_front(); total_cnt++;
    if ({31'b0, rd_busy2[0]} !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_busy2[0], e.value);
    else pass_cnt++;
    wr_en2 = 1'b1;
    wr_addr2 = 5'd23;
    wr_data2 = 32'h2323_0017;
    rd_addr2 = {5'd23, 5'd23, 5'd23};
    #1;
    for (int i = 0; i < 3; i++) push($sformatf("d24_bypass_port%0d", i), 32'h2323_0017);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front(); total_cnt++;
      if (rd_data2[i*32 +: 32] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data2[i*32 +: 32], e.value);
      else pass_cnt++;
    end
    tick();
    wr_en2 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) push($sformatf("d24_stored_port%0d", i), 32'h2323_0017);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front(); total_cnt++;
      if (rd_data2[i*32 +: 32] !== e.value) $display("FAIL %s: got %h want %h", e.name, rd_data2[i*32 +: 32], e.value);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_depth24();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
